// File: rtl/chscan.sv
// Channel scanner for a 4:1 data selector: strobes each channel, samples the selector
// output and presents the assembled word over valid/ack. Optional parity: CHSCAN_PARITY_EN.
module chscan #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned SWIDTH = 4
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic       startin,
    input  logic       ackin,
    input  logic       yin,
    output logic       aout,
    output logic       bout,
    output logic       gbout,
    output logic [3:0] dataout,
    output logic       validout,
    output logic       busyout,
    output logic       parout
);

    typedef enum logic [1:0] {IDLE, PREP, WAIT, DONE} state_e;

    // A settle of 0 is treated as 1 so every channel gets at least one strobe cycle.
    localparam logic [SWIDTH-1:0] SETTLE_LD = (SETTLE == 0) ? SWIDTH'(1) : SWIDTH'(SETTLE);

    state_e            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic [SWIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic              gb_q, gb_d;
    logic [3:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
`ifdef CHSCAN_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            gb_q    <= 1'b1;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CHSCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gb_q    <= gb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef CHSCAN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state plus registered-output decode from the next state.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
`ifdef CHSCAN_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (startin) begin
                    state_d = PREP;
                    ch_d    = 2'd0;
                end
            end
            PREP: begin
                state_d = WAIT;
                cnt_d   = SETTLE_LD;
            end
            WAIT: begin
                cnt_d = cnt_q - SWIDTH'(1);
                if (cnt_q <= SWIDTH'(1)) begin
                    data_d[ch_q] = yin;
                    if (ch_q == 2'd3) begin
                        state_d = DONE;
`ifdef CHSCAN_PARITY_EN
                        par_d   = yin ^ data_q[2] ^ data_q[1] ^ data_q[0];
`endif
                    end else begin
                        state_d = PREP;
                        ch_d    = ch_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (ackin) begin
                    if (startin) begin
                        state_d = PREP;
                        ch_d    = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Selects only move when entering PREP; they hold through WAIT and DONE.
        if (state_d == PREP) sel_d = ch_d;
        gb_d    = (state_d != WAIT);
        busy_d  = (state_d == PREP) || (state_d == WAIT);
        valid_d = (state_d == DONE);
    end

    assign aout     = sel_q[0];
    assign bout     = sel_q[1];
    assign gbout    = gb_q;
    assign dataout  = data_q;
    assign validout = valid_q;
    assign busyout  = busy_q;
`ifdef CHSCAN_PARITY_EN
    assign parout   = par_q;
`else
    assign parout   = 1'b0;
`endif

endmodule

// File: tb/tb_chscan.sv
// Bench for chscan: two instances (SETTLE=1 and SETTLE=3), each driving a
// behavioural 4:1 selector that re-evaluates only on select/strobe transitions.
module tb_chscan;

`ifdef CHSCAN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]      start = '0;
    logic [1:0]      ack   = '0;
    logic [1:0][3:0] cin   = '0;
    logic [1:0]      a, b, gb, valid, busy, par;
    logic [1:0][3:0] data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic y_l;
        chscan #(.SETTLE((g == 0) ? 1 : 3), .SWIDTH(4)) u_dut (
            .clkin(clk), .rstin(rst), .startin(start[g]), .ackin(ack[g]), .yin(y_l),
            .aout(a[g]), .bout(b[g]), .gbout(gb[g]), .dataout(data[g]),
            .validout(valid[g]), .busyout(busy[g]), .parout(par[g])
        );
        always @(gb[g], a[g], b[g]) y_l = gb[g] ? 1'b0 : cin[g][{b[g], a[g]}];
    end

    typedef struct {
        int         inst;
        logic [3:0] c;
        logic [3:0] exp_d;
        int         exp_lat;
        int         exp_lows;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_par(input logic [3:0] d);
        return PAR_EN ? int'(^d) : 0;
    endfunction

    // Count edges until validout, tracking strobe activity; optionally poke startin mid-scan.
    task automatic wait_valid(input int k, input bit poke, output int lat, output int lows,
                              output int falls);
        bit prev = 1'b1;
        bit done = 1'b0;
        lat = 0; lows = 0; falls = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (poke) start[k] = (lat == 3 || lat == 6);
            if (!gb[k]) lows++;
            if (prev && !gb[k]) falls++;
            prev = gb[k];
            if (valid[k]) done = 1'b1;
        end
        start[k] = 1'b0;
        if (!done) check("valid_timeout", 0, 1);
    endtask

    task automatic do_scan(input int k, input logic [3:0] cv, input bit poke, output int lat,
                           output int lows, output int falls);
        @(negedge clk);
        cin[k]   = cv;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        wait_valid(k, poke, lat, lows, falls);
    endtask

    task automatic do_ack(input int k);
        ack[k] = 1'b1;
        @(negedge clk);
        ack[k] = 1'b0;
        check("ack_valid_clr", int'(valid[k]), 0);
        check("ack_busy", int'(busy[k]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lows, falls;
        bit stable;

        vecs[0] = '{0, 4'b1101, 4'b1101, 8, 4};
        vecs[1] = '{1, 4'b0110, 4'b0110, 16, 12};
        vecs[2] = '{0, 4'b0000, 4'b0000, 8, 4};
        vecs[3] = '{0, 4'b1111, 4'b1111, 8, 4};
        vecs[4] = '{1, 4'b1010, 4'b1010, 16, 12};
        vecs[5] = '{1, 4'b0001, 4'b0001, 16, 12};

        // Power-on reset values
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_sel", int'({b[k], a[k]}), 0);
            check("rst_gb", int'(gb[k]), 1);
            check("rst_data", int'(data[k]), 0);
            check("rst_valid", int'(valid[k]), 0);
            check("rst_busy", int'(busy[k]), 0);
            check("rst_par", int'(par[k]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset while strobing channel 2 (SETTLE=1: WAIT ch2 follows edge 5)
        @(negedge clk);
        cin[0]   = 4'b1111;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_gb", int'(gb[0]), 0);
        check("mid_sel", int'({b[0], a[0]}), 2);
        check("mid_data", int'(data[0]), 3);
        rst = 1'b1;
        #1;
        check("arst_sel", int'({b[0], a[0]}), 0);
        check("arst_gb", int'(gb[0]), 1);
        check("arst_data", int'(data[0]), 0);
        check("arst_valid", int'(valid[0]), 0);
        check("arst_busy", int'(busy[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", int'(busy[0]), 0);
        check("post_rst_gb", int'(gb[0]), 1);
        check("post_rst_valid", int'(valid[0]), 0);

        // Table-driven scans
        for (int i = 0; i < 6; i++) begin
            do_scan(vecs[i].inst, vecs[i].c, 1'b0, lat, lows, falls);
            check("latency", lat, vecs[i].exp_lat);
            check("gb_low_cycles", lows, vecs[i].exp_lows);
            check("gb_strobes", falls, 4);
            check("data", int'(data[vecs[i].inst]), int'(vecs[i].exp_d));
            check("parity", int'(par[vecs[i].inst]), exp_par(vecs[i].exp_d));
            check("done_sel", int'({b[vecs[i].inst], a[vecs[i].inst]}), 3);
            check("done_busy", int'(busy[vecs[i].inst]), 0);
            check("done_gb", int'(gb[vecs[i].inst]), 1);
            do_ack(vecs[i].inst);
        end

        // Hold in DONE without ack while selector inputs change
        do_scan(1, 4'b0110, 1'b0, lat, lows, falls);
        check("hold_lat", lat, 16);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cin[1] = 4'(i + 5);
            @(negedge clk);
            if (data[1] !== 4'b0110 || valid[1] !== 1'b1) stable = 1'b0;
        end
        check("hold_stable", int'(stable), 1);
        check("hold_data", int'(data[1]), 6);
        check("hold_par", int'(par[1]), exp_par(4'b0110));
        do_ack(1);
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy[1]), 0);
        check("idle_valid", int'(valid[1]), 0);

        // Back-to-back: ack+start together restarts at channel 0, mid-scan starts ignored
        do_scan(0, 4'b1101, 1'b0, lat, lows, falls);
        check("b2b_first", int'(data[0]), 13);
        ack[0]   = 1'b1;
        start[0] = 1'b1;
        cin[0]   = 4'b0010;
        @(negedge clk);
        ack[0]   = 1'b0;
        start[0] = 1'b0;
        check("b2b_busy", int'(busy[0]), 1);
        check("b2b_gb", int'(gb[0]), 1);
        check("b2b_sel", int'({b[0], a[0]}), 0);
        check("b2b_valid", int'(valid[0]), 0);
        check("b2b_keep_old", int'(data[0]), 13);
        wait_valid(0, 1'b1, lat, lows, falls);
        check("b2b_lat", lat, 8);
        check("b2b_strobes", falls, 4);
        check("b2b_data", int'(data[0]), 2);
        check("b2b_par", int'(par[0]), exp_par(4'b0010));
        do_ack(0);
        repeat (3) @(negedge clk);
        check("b2b_no_restart", int'(busy[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chscan.md
Name: chscan

Overview:
- Sequencer that sits directly upstream of the 4:1 data selector and also consumes its output.
- On a start request it walks the select lines through channels 0..3 and drives the active-low strobe.
- After a settle time per channel it samples the selector output and assembles the four samples into a 4-bit word.
- The word is presented with a valid/ack handshake to the downstream consumer.

Parameters:
SETTLE, 1, cycles the strobe is held active per channel before sampling; legal 1..2^SWIDTH-1; 0 behaves as 1
SWIDTH, 4, width of the internal settle counter

Ports:
clkin  input  1  clock, all state on rising edge
rstin  input  1  reset, asynchronous, active-high
startin  input  1  scan request, sampled in IDLE (and in DONE together with ackin)
ackin  input  1  consumer acknowledge of dataout, sampled in DONE
yin  input  1  selector output (yout of the data selector)
aout  output  1  select LSB to selector ain
bout  output  1  select MSB to selector bin
gbout  output  1  active-low strobe to selector gbin
dataout  output  4  assembled word, bit n = sample of channel n
validout  output  1  dataout valid, held until acknowledged
busyout  output  1  scan in progress
parout  output  1  even parity of dataout (see Optional Feature)

Behaviour:
- Reset values (async assert, any state): state=IDLE, aout=0, bout=0, gbout=1, dataout=0, validout=0, busyout=0, parout=0, channel index=0, counter=0.
- The selector re-evaluates only on select/strobe transitions. The scanner therefore forces gbout=1 for one cycle before every channel, so each channel produces a fresh strobe edge.
- States: IDLE, PREP, WAIT, DONE.
- IDLE:
  - gbout=1, busyout=0.
  - startin=1 -> PREP with channel=0.
- PREP:
  - {bout,aout}=channel, gbout=1, busyout=1.
  - Lasts 1 cycle, loads counter=SETTLE, then -> WAIT.
- WAIT:
  - gbout=0, selects unchanged, busyout=1.
  - Counter decrements each edge.
  - On the edge where counter==1: dataout[channel] <= yin.
  - Then if channel==3 -> DONE, else channel+1 and -> PREP.
- DONE:
  - gbout=1, busyout=0, validout=1.
  - dataout and parout held stable.
  - ackin=1 -> validout=0 next edge, and:
    - if startin=1 in the same cycle -> PREP, channel 0 (back-to-back scan);
    - else -> IDLE.
- Latency: validout rises exactly 4*(SETTLE+1) rising edges after the edge that samples startin=1.
- Bit handling: dataout bits are written individually. Bits of a new scan overwrite the old word progressively; the old word is not cleared at scan start.
- startin is ignored in PREP/WAIT. ackin is ignored outside DONE.
- Reset asserted mid-scan: the partial word is discarded, all outputs take reset values immediately, and after release the block waits in IDLE.
- aout/bout keep their last channel value (3) in DONE; they return to 0 only on reset or the next PREP.

Optional Feature:
- Macro CHSCAN_PARITY_EN.
- Defined: parout registered alongside the final sample as XOR of all four dataout bits, valid while validout=1, held in DONE.
- Undefined: parout tied to 0 and no parity logic is built; all other behaviour is identical.

Test Plan:
- Reset during WAIT of channel 2 -> aout=0, bout=0, gbout=1, dataout=0, validout=0, busyout=0 same cycle; stays IDLE after release.
- SETTLE=1, selector inputs c0=1 c1=0 c2=1 c3=1, pulse startin -> validout=1 exactly 8 edges later, dataout=4'b1101, gbout high one cycle before each channel.
- SETTLE=3, c0..c3 = 0,1,1,0 -> validout after 16 edges, dataout=4'b0110, gbout low 3 cycles per channel.
- Hold ackin=0 for 10 cycles in DONE, change c inputs -> dataout stays 4'b0110, validout stays 1; ackin=1 with startin=0 -> IDLE, validout=0.
- ackin=1 and startin=1 same cycle in DONE -> PREP channel 0 next edge; startin pulses during the scan are ignored, no restart.
- CHSCAN_PARITY_EN defined, word 4'b1101 -> parout=1; word 4'b0110 -> parout=0; undefined -> parout=0 always.
